// File: rtl/verify_result_display.sv
// Captures the demo's 16 per-word pass flags, reduces them serially to a pass count
// and first-failure index, and scans both onto an 8-digit seven-segment display.
module verify_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RESULT_VALID,
  input  logic [15:0] RESULT_FLAGS,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        DONE,
  output logic        ALL_PASS
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;

  state_t           state, state_nxt;
  logic             rv_q;
  logic [15:0]      flag_r, flag_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [4:0]       count, count_nxt;
  logic [3:0]       first, first_nxt;
  logic             found, found_nxt;
  logic [2:0]       digit, digit_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [7:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             done_nxt, all_pass_nxt;
  logic             rise;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Values never exceed 16, so a single compare against 10 gives the decimal split.
  function automatic logic [3:0] tens_of(input logic [4:0] v);
    return (v >= 5'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [4:0] v);
    logic [4:0] r;
    r = (v >= 5'd10) ? (v - 5'd10) : v;
    return r[3:0];
  endfunction

  function automatic logic [6:0] digit_seg(input logic [2:0] d, input logic [4:0] cnt,
                                           input logic [3:0] fst, input logic fnd);
    case (d)
      3'd7:    return seg_of(tens_of(cnt));
      3'd6:    return seg_of(ones_of(cnt));
      3'd1:    return fnd ? seg_of(tens_of({1'b0, fst})) : SEG_DASH;
      3'd0:    return fnd ? seg_of(ones_of({1'b0, fst})) : SEG_DASH;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign rise = RESULT_VALID & ~rv_q;

  // rv_q keeps tracking through reset so a level held across reset is not seen as an edge.
  always_ff @(posedge CLK) begin
    rv_q <= RESULT_VALID;
  end

  always_comb begin
    state_nxt    = state;
    flag_nxt     = flag_r;
    idx_nxt      = idx;
    count_nxt    = count;
    first_nxt    = first;
    found_nxt    = found;
    digit_nxt    = digit;
    div_nxt      = div;
    an_nxt       = 8'hFF;
    seg_nxt      = SEG_BLANK;
    done_nxt     = 1'b0;
    all_pass_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          flag_nxt  = RESULT_FLAGS;
          idx_nxt   = 4'd0;
          count_nxt = 5'd0;
          first_nxt = 4'd0;
          found_nxt = 1'b0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!RESULT_VALID) begin
          state_nxt = IDLE;
        end else begin
          if (flag_r[idx]) begin
            count_nxt = count + 5'd1;
          end else if (!found) begin
            first_nxt = idx;
            found_nxt = 1'b1;
          end
          if (idx == 4'd15) begin
            state_nxt = SHOW;
            digit_nxt = 3'd0;
            div_nxt   = '0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      SHOW: begin
        if (!RESULT_VALID) begin
          state_nxt = IDLE;
        end else if (div == DIV_LAST) begin
          div_nxt   = '0;
          digit_nxt = digit + 3'd1;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    if (state_nxt == SHOW) begin
      done_nxt     = 1'b1;
      all_pass_nxt = (count_nxt == 5'd16);
      an_nxt       = ~(8'b1 << digit_nxt);
      seg_nxt      = digit_seg(digit_nxt, count_nxt, first_nxt, found_nxt);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      flag_r   <= '0;
      idx      <= '0;
      count    <= '0;
      first    <= '0;
      found    <= 1'b0;
      digit    <= '0;
      div      <= '0;
      AN       <= 8'hFF;
      SEG      <= SEG_BLANK;
      DP       <= 1'b1;
      DONE     <= 1'b0;
      ALL_PASS <= 1'b0;
    end else begin
      state    <= state_nxt;
      flag_r   <= flag_nxt;
      idx      <= idx_nxt;
      count    <= count_nxt;
      first    <= first_nxt;
      found    <= found_nxt;
      digit    <= digit_nxt;
      div      <= div_nxt;
      AN       <= an_nxt;
      SEG      <= seg_nxt;
      DP       <= 1'b1;
      DONE     <= done_nxt;
      ALL_PASS <= all_pass_nxt;
    end
  end

endmodule

// File: tb/tb_verify_result_display.sv
// Directed bench for verify_result_display with SCAN_DIV = 4: scan latency,
// digit contents, scan timing, abort, and reset during display.
module tb_verify_result_display;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RESULT_VALID;
  logic [15:0] RESULT_FLAGS;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        DONE;
  logic        ALL_PASS;

  int n_cmp  = 0;
  int n_fail = 0;

  verify_result_display #(.SCAN_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .RESULT_VALID(RESULT_VALID), .RESULT_FLAGS(RESULT_FLAGS),
    .AN(AN), .SEG(SEG), .DP(DP), .DONE(DONE), .ALL_PASS(ALL_PASS)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise RESULT_VALID with the given flags, check latency, then walk all 8 digits.
  task automatic run_scan(input string name, input logic [15:0] flags, input logic [6:0] s7,
                          input logic [6:0] s6, input logic [6:0] s1, input logic [6:0] s0,
                          input logic ap);
    logic [6:0] exp_seg [8];
    logic [7:0] exp_an;
    exp_seg = '{s0, s1, 7'h7F, 7'h7F, 7'h7F, 7'h7F, s6, s7};
    RESULT_FLAGS = flags;
    RESULT_VALID = 1'b1;
    tick(8);
    chk({name, " scan_an"}, {24'd0, AN}, 32'hFF);
    tick(8);
    chk({name, " done_at16"}, {31'd0, DONE}, 32'd0);
    tick(1);
    chk({name, " done_at17"}, {31'd0, DONE}, 32'd1);
    chk({name, " all_pass"}, {31'd0, ALL_PASS}, {31'd0, ap});
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'b1 << d);
      chk($sformatf("%s an%0d_start", name, d), {24'd0, AN}, {24'd0, exp_an});
      chk($sformatf("%s seg%0d", name, d), {25'd0, SEG}, {25'd0, exp_seg[d]});
      tick(3);
      chk($sformatf("%s an%0d_end", name, d), {24'd0, AN}, {24'd0, exp_an});
      tick(1);
    end
    chk({name, " an_wrap"}, {24'd0, AN}, 32'hFE);
    chk({name, " seg_wrap"}, {25'd0, SEG}, {25'd0, s0});
    RESULT_VALID = 1'b0;
    tick(1);
    chk({name, " drop_an"}, {24'd0, AN}, 32'hFF);
    chk({name, " drop_seg"}, {25'd0, SEG}, 32'h7F);
    chk({name, " drop_done"}, {31'd0, DONE}, 32'd0);
    chk({name, " drop_ap"}, {31'd0, ALL_PASS}, 32'd0);
    tick(2);
  endtask

  initial begin
    RST = 1'b1;
    RESULT_VALID = 1'b0;
    RESULT_FLAGS = 16'h0000;
    tick(2);
    chk("rst_an", {24'd0, AN}, 32'hFF);
    chk("rst_seg", {25'd0, SEG}, 32'h7F);
    chk("rst_dp", {31'd0, DP}, 32'd1);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_ap", {31'd0, ALL_PASS}, 32'd0);
    RST = 1'b0;
    tick(2);

    run_scan("ffff", 16'hFFFF, 7'h79, 7'h02, 7'h3F, 7'h3F, 1'b1);
    run_scan("fff7", 16'hFFF7, 7'h79, 7'h12, 7'h40, 7'h30, 1'b0);
    run_scan("0000", 16'h0000, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
    run_scan("7fff", 16'h7FFF, 7'h79, 7'h12, 7'h79, 7'h12, 1'b0);

    // Abort part-way through the scan.
    RESULT_FLAGS = 16'hFFFF;
    RESULT_VALID = 1'b1;
    tick(9);
    RESULT_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk($sformatf("abort_done%0d", i), {31'd0, DONE}, 32'd0);
      chk($sformatf("abort_an%0d", i), {24'd0, AN}, 32'hFF);
    end
    run_scan("feff", 16'hFEFF, 7'h79, 7'h12, 7'h40, 7'h00, 1'b0);

    // Reset while the display is active, with RESULT_VALID held high throughout.
    RESULT_FLAGS = 16'hFFFF;
    RESULT_VALID = 1'b1;
    tick(17);
    chk("pre_rst_done", {31'd0, DONE}, 32'd1);
    tick(5);
    RST = 1'b1;
    tick(1);
    chk("mid_rst_an", {24'd0, AN}, 32'hFF);
    chk("mid_rst_seg", {25'd0, SEG}, 32'h7F);
    chk("mid_rst_done", {31'd0, DONE}, 32'd0);
    chk("mid_rst_ap", {31'd0, ALL_PASS}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk($sformatf("norescan_done%0d", i), {31'd0, DONE}, 32'd0);
      chk($sformatf("norescan_an%0d", i), {24'd0, AN}, 32'hFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
